// File: rtl/memory_access.sv
// Y86 data-memory stage: 8-byte little-endian load/store against an internal
// byte memory, with a configurable wait latency and a start/done handshake.
module memory_access #(
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [3:0]  icode_i,
  input  logic [63:0] valE_i,
  input  logic [63:0] valA_i,
  input  logic [63:0] valP_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] valM_o,
  output logic        dmem_error_o,
  output logic [1:0]  state_o
);

  localparam int          AW       = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);
  localparam logic [3:0]  LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: a request is accepted on any rising edge where start_i is high
  // and busy_o is low; its result is valid while done_o is high (one cycle).
  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;

  logic        req_wr, req_rd;
  logic [63:0] req_addr, req_data;
  logic        op_wr, op_rd;
  logic [63:0] op_addr, op_data;
  logic        cur_wr, cur_rd, cur_err;
  logic [63:0] cur_addr, cur_data;
  logic        accept, finish;

  logic [7:0]    mem [MEM_BYTES];
  logic [AW-1:0] idx;
  logic [63:0]   rdata;

  always_comb begin
    req_wr   = 1'b0;
    req_rd   = 1'b0;
    req_addr = valE_i;
    req_data = valA_i;
    case (icode_i)
      IRMMOVQ, IPUSHQ: req_wr = 1'b1;
      ICALL: begin
        req_wr   = 1'b1;
        req_data = valP_i;
      end
      IMRMOVQ: req_rd = 1'b1;
      IPOPQ, IRET: begin
        req_rd   = 1'b1;
        req_addr = valA_i;
      end
      default: ;
    endcase
  end

  // Outside WAIT the access completes on the accept edge, so use live inputs.
  always_comb begin
    if (state == WAIT) begin
      cur_wr   = op_wr;
      cur_rd   = op_rd;
      cur_addr = op_addr;
      cur_data = op_data;
    end else begin
      cur_wr   = req_wr;
      cur_rd   = req_rd;
      cur_addr = req_addr;
      cur_data = req_data;
    end
    cur_err = (cur_wr | cur_rd) && (cur_addr > MAX_ADDR);
    idx     = cur_addr[AW-1:0];
    rdata   = '0;
    for (int i = 0; i < 8; i++) begin
      rdata[8*i +: 8] = mem[idx + AW'(i)];
    end
  end

  assign accept = start_i && (state != WAIT);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      WAIT: begin
        if (cnt == 4'd0) state_n = DONE;
        else             cnt_n   = cnt - 4'd1;
      end
      default: begin
        if (start_i) begin
          if ((req_wr | req_rd) && !cur_err && (LATENCY != 0)) begin
            state_n = WAIT;
            cnt_n   = LAT_LOAD;
          end else begin
            state_n = DONE;
          end
        end else begin
          state_n = IDLE;
        end
      end
    endcase
  end

  assign finish = (state_n == DONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      op_wr        <= 1'b0;
      op_rd        <= 1'b0;
      op_addr      <= '0;
      op_data      <= '0;
      valM_o       <= '0;
      dmem_error_o <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        op_wr   <= req_wr;
        op_rd   <= req_rd;
        op_addr <= req_addr;
        op_data <= req_data;
      end
      if (finish) begin
        valM_o       <= (cur_rd && !cur_err) ? rdata : 64'd0;
        dmem_error_o <= cur_err;
      end
    end
  end

  // Memory contents survive reset; reset only blocks a store from committing.
  always_ff @(posedge clk_i) begin
    if (!rst_i && finish && cur_wr && !cur_err) begin
      for (int i = 0; i < 8; i++) begin
        mem[idx + AW'(i)] <= cur_data[8*i +: 8];
      end
    end
  end

  assign busy_o  = (state == WAIT);
  assign done_o  = (state == DONE);
  assign state_o = state;

endmodule
